mdio_responder: RTL
===================

Name: mdio_responder

Overview:
- PHY-side MDIO slave: the target end of the Clause-22 management link driven by our MDIO initiator.
- Decodes serial frames arriving on MDC/MDIO: preamble, ST, OP, PHYAD, REGAD, TA, DATA.
- Write frames produce a one-cycle register-write strobe. Read frames fetch a register value and shift it back on MDIO.
- Runs entirely in the CLK domain. MDC and MDIO are oversampled; CLK must be at least 8x the MDC frequency.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on MDC and MDIO_IN before edge detect (minimum 2).
- PREAMBLE_LEN, 32, consecutive 1s required before ST when preamble is mandatory (range 1..32).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-low reset.
- MDC  in  1  management clock from the initiator (asynchronous to CLK).
- MDIO_IN  in  1  serial data from the pad.
- MDIO_OUT  out  1  serial data to the pad.
- MDIO_OE  out  1  pad output enable; 1 = responder drives.
- PHY_ADDR  in  5  this responder's address; must be held static.
- WR_STB  out  1  one-CLK pulse: write frame accepted.
- WR_ADDR  out  5  register address of the last write.
- WR_DATA  out  16  data of the last write.
- RD_STB  out  1  one-CLK pulse: read request.
- RD_ADDR  out  5  register address of the read.
- RD_DATA  in  16  read value; must be valid 2 CLK after RD_STB and held until the frame ends.
- BUSY  out  1  high from ST detection until return to IDLE.
- FRAME_ERR  out  1  one-CLK pulse on a malformed addressed frame.

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - All outputs cleared: MDIO_OUT=0, MDIO_OE=0, WR_STB=0, WR_ADDR=0, WR_DATA=0, RD_STB=0, RD_ADDR=0, BUSY=0, FRAME_ERR=0.
  - State returns to IDLE; preamble and bit counters cleared; synchronizers cleared.
- Sampling:
  - A bit is the synchronized MDIO value at a detected MDC rising edge (rise_det).
  - All state advances only on rise_det.
  - MDIO_OUT/MDIO_OE update in the same CLK as rise_det, so they hold across the following MDC rising edge.
- States: IDLE, START, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP. A 5-bit counter tracks position within a field.
- IDLE:
  - Counts consecutive 1 bits, saturating at 32.
  - A 0 bit with count >= PREAMBLE_LEN -> START, BUSY=1.
  - A 0 bit with count < PREAMBLE_LEN clears the count and stays in IDLE.
- START: bit must be 1, otherwise return to IDLE silently.
- OP: 2 bits. 10 = read, 01 = write. 00 or 11 -> IDLE silently.
- PHYAD: 5 bits MSB first. On mismatch with PHY_ADDR, go to SKIP for the remaining 18 bits (TA + DATA), driving nothing.
- REGAD:
  - 5 bits MSB first.
  - For a read, RD_ADDR is loaded and RD_STB pulses on the CLK of the last REGAD bit.
- TA, read:
  - 1st TA bit: OE stays 0.
  - 2nd TA bit: OE=1, OUT=0. RD_DATA is captured into the shift register at this point.
- TA, write:
  - Expects 1 then 0.
  - On mismatch: FRAME_ERR pulse, go to SKIP for 16 bits, no WR_STB.
- RDATA:
  - Drives 16 bits MSB first, one per rise_det.
  - At the rise_det after the last bit: OE=0, OUT=0, go to IDLE.
- WDATA:
  - Shifts in 16 bits.
  - On the 16th bit: WR_ADDR/WR_DATA load and WR_STB pulses in the same CLK; go to IDLE.
- SKIP: counts out the remaining bits, then goes to IDLE with OE=0.
- General rules:
  - BUSY falls on IDLE entry.
  - WR_ADDR/WR_DATA/RD_ADDR hold their value between frames.
- Reset mid-frame: OE drops at that CLK; no strobe is issued; the next frame needs a full preamble.
- MDC stopped mid-frame: state holds indefinitely; there is no timeout.

Optional Feature:
- Macro: MDIO_PREAMBLE_SUPPRESS_EN.
- Defined:
  - IDLE accepts ST after any run of at least one 1 bit, so preamble-suppressed back-to-back frames are legal.
  - The preamble counter is not instantiated.
- Undefined: PREAMBLE_LEN consecutive 1s are mandatory.

Test Plan:
- Write: PHY_ADDR=03, 32x1 + 0101 00011 01010 10 BEEF -> exactly one WR_STB; WR_ADDR=0A, WR_DATA=BEEF; MDIO_OE never 1; BUSY low afterwards.
- Read: PHY_ADDR=03, REGAD=02, RD_DATA=1234 -> RD_STB once with RD_ADDR=02. MDIO_OE is 1 for 17 bit times; the line carries 0 then 0001001000110100; OE=0 afterwards.
- Address mismatch: PHYAD=04 with PHY_ADDR=03 (read) -> no strobes, OE stays 0; an immediately following correct write is accepted.
- Bad TA: write frame with TA=11 -> FRAME_ERR single pulse, no WR_STB. Bad OP=11 -> no FRAME_ERR, back to IDLE.
- Short preamble: 20x1 then a valid write -> ignored when the macro is undefined; accepted with WR_STB when MDIO_PREAMBLE_SUPPRESS_EN is defined.
- Reset during RDATA bit 5 -> MDIO_OE=0 and BUSY=0 on the reset CLK; the following full frame completes normally.

Source files
------------

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target: decodes MDC/MDIO frames in the CLK domain, strobes register writes and reads.
// Optional MDIO_PREAMBLE_SUPPRESS_EN: accept ST after any run of 1s instead of PREAMBLE_LEN of them.
//   state   | meaning
//   IDLE    | counting preamble 1s, waiting for the ST 0 bit
//   START   | second ST bit, must be 1
//   OP      | 2-bit opcode, 10 read / 01 write
//   PHYAD   | 5-bit PHY address, compared on the last bit
//   REGAD   | 5-bit register address, read request issued on the last bit
//   TA      | turnaround; read starts driving, write checks 1-then-0
//   RDATA   | shifting 16 read bits out, then releasing the pad
//   WDATA   | shifting 16 write bits in
//   SKIP    | discarding the rest of a frame not meant for us
module mdio_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDC,
    input  logic        MDIO_IN,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    input  logic [4:0]  PHY_ADDR,
    output logic        WR_STB,
    output logic [4:0]  WR_ADDR,
    output logic [15:0] WR_DATA,
    output logic        RD_STB,
    output logic [4:0]  RD_ADDR,
    input  logic [15:0] RD_DATA,
    output logic        BUSY,
    output logic        FRAME_ERR
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_RDATA, S_WDATA, S_SKIP
    } state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d, mdio_sync_q, mdio_sync_d;
    logic        mdc_prev_q, mdc_prev_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  regad_q, regad_d;
    logic        is_read_q, is_read_d;
    logic        mismatch_q, mismatch_d;
    logic        ta_first_q, ta_first_d;
    logic        mdio_out_q, mdio_out_d, mdio_oe_q, mdio_oe_d;
    logic        wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
    logic [4:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        busy_q, busy_d, frame_err_q, frame_err_d;
    logic        rise_det, bit_in, pre_ok, pre_hit, pre_clr;

    assign rise_det = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
    assign bit_in   = mdio_sync_q[SYNC_STAGES-1];

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic one_seen_q, one_seen_d;
    assign pre_ok = one_seen_q;
    always_comb begin
        one_seen_d = one_seen_q;
        if (pre_clr)      one_seen_d = 1'b0;
        else if (pre_hit) one_seen_d = 1'b1;
    end
    always_ff @(posedge CLK) begin
        if (!RESET) one_seen_q <= 1'b0;
        else        one_seen_q <= one_seen_d;
    end
`else
    logic [5:0] pre_cnt_q, pre_cnt_d;
    assign pre_ok = (pre_cnt_q >= 6'(PREAMBLE_LEN));
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (pre_clr)                             pre_cnt_d = 6'd0;
        else if (pre_hit && pre_cnt_q != 6'd32)  pre_cnt_d = pre_cnt_q + 6'd1;
    end
    always_ff @(posedge CLK) begin
        if (!RESET) pre_cnt_q <= 6'd0;
        else        pre_cnt_q <= pre_cnt_d;
    end
`endif

    always_comb begin
        mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], MDC};
        mdio_sync_d = {mdio_sync_q[SYNC_STAGES-2:0], MDIO_IN};
        mdc_prev_d  = mdc_sync_q[SYNC_STAGES-1];
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        regad_d     = regad_q;
        is_read_d   = is_read_q;
        mismatch_d  = mismatch_q;
        ta_first_d  = ta_first_q;
        mdio_out_d  = mdio_out_q;
        mdio_oe_d   = mdio_oe_q;
        wr_stb_d    = 1'b0;
        rd_stb_d    = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        pre_hit     = 1'b0;
        pre_clr     = (state_q != S_IDLE);

        if (rise_det) begin
            case (state_q)
                S_IDLE: begin
                    if (bit_in) begin
                        pre_hit = 1'b1;
                    end else begin
                        pre_clr = 1'b1;
                        if (pre_ok) begin
                            state_d = S_START;
                            busy_d  = 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (bit_in) begin
                        state_d = S_OP;
                        cnt_d   = 5'd1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                S_OP: begin
                    shift_d = {shift_q[14:0], bit_in};
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else if ({shift_q[0], bit_in} == 2'b10 || {shift_q[0], bit_in} == 2'b01) begin
                        is_read_d = shift_q[0];
                        state_d   = S_PHYAD;
                        cnt_d     = 5'd4;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                S_PHYAD: begin
                    shift_d = {shift_q[14:0], bit_in};
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        mismatch_d = ({shift_q[3:0], bit_in} != PHY_ADDR);
                        state_d    = S_REGAD;
                        cnt_d      = 5'd4;
                    end
                end
                S_REGAD: begin
                    shift_d = {shift_q[14:0], bit_in};
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else if (mismatch_q) begin
                        // Not ours: swallow TA and DATA so data bits never look like a preamble
                        state_d = S_SKIP;
                        cnt_d   = 5'd17;
                    end else begin
                        regad_d = {shift_q[3:0], bit_in};
                        state_d = S_TA;
                        cnt_d   = 5'd1;
                        if (is_read_q) begin
                            rd_stb_d  = 1'b1;
                            rd_addr_d = {shift_q[3:0], bit_in};
                        end
                    end
                end
                S_TA: begin
                    if (cnt_q != 5'd0) begin
                        ta_first_d = bit_in;
                        cnt_d      = 5'd0;
                    end else if (is_read_q) begin
                        mdio_oe_d  = 1'b1;
                        mdio_out_d = 1'b0;
                        shift_d    = RD_DATA;
                        state_d    = S_RDATA;
                        cnt_d      = 5'd16;
                    end else if (ta_first_q && !bit_in) begin
                        state_d = S_WDATA;
                        cnt_d   = 5'd15;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_SKIP;
                        cnt_d       = 5'd15;
                    end
                end
                S_RDATA: begin
                    if (cnt_q != 5'd0) begin
                        mdio_out_d = shift_q[15];
                        shift_d    = {shift_q[14:0], 1'b0};
                        cnt_d      = cnt_q - 5'd1;
                    end else begin
                        mdio_oe_d  = 1'b0;
                        mdio_out_d = 1'b0;
                        state_d    = S_IDLE;
                        busy_d     = 1'b0;
                    end
                end
                S_WDATA: begin
                    shift_d = {shift_q[14:0], bit_in};
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        wr_data_d = {shift_q[14:0], bit_in};
                        wr_addr_d = regad_q;
                        wr_stb_d  = 1'b1;
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                    end
                end
                S_SKIP: begin
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        mdio_oe_d = 1'b0;
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                    end
                end
                default: begin
                    mdio_oe_d = 1'b0;
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
            mdc_prev_q  <= 1'b0;
            cnt_q       <= 5'd0;
            shift_q     <= 16'd0;
            regad_q     <= 5'd0;
            is_read_q   <= 1'b0;
            mismatch_q  <= 1'b0;
            ta_first_q  <= 1'b0;
            mdio_out_q  <= 1'b0;
            mdio_oe_q   <= 1'b0;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 16'd0;
            rd_addr_q   <= 5'd0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mdc_sync_q  <= mdc_sync_d;
            mdio_sync_q <= mdio_sync_d;
            mdc_prev_q  <= mdc_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            regad_q     <= regad_d;
            is_read_q   <= is_read_d;
            mismatch_q  <= mismatch_d;
            ta_first_q  <= ta_first_d;
            mdio_out_q  <= mdio_out_d;
            mdio_oe_q   <= mdio_oe_d;
            wr_stb_q    <= wr_stb_d;
            rd_stb_q    <= rd_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign MDIO_OUT  = mdio_out_q;
    assign MDIO_OE   = mdio_oe_q;
    assign WR_STB    = wr_stb_q;
    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign RD_STB    = rd_stb_q;
    assign RD_ADDR   = rd_addr_q;
    assign BUSY      = busy_q;
    assign FRAME_ERR = frame_err_q;

endmodule
